// File: rtl/lvds_line_buffer_pkg.sv
// Shared constants and types for the LVDS ping-pong line buffer and its transmitter.
// Display timing, word layout and colour packing live here so both blocks agree.
package lvds_line_buffer_pkg;

  localparam int LB_HACTIVE = 960;
  localparam int LB_VACTIVE = 1200;
  localparam int LB_HFRONT  = 24;
  localparam int LB_VFRONT  = 3;
  localparam int LB_AW      = 10;
  localparam int LB_PIX_W   = 24;
  localparam int LB_WORD_W  = 2 * LB_PIX_W;
  localparam logic [LB_PIX_W-1:0] LB_UNDERRUN_COLOR = 24'hFF00FF;

  // Even pixel occupies the upper half of every dual-pixel word.
  typedef struct packed {
    logic [LB_PIX_W-1:0] color_even;
    logic [LB_PIX_W-1:0] color;
  } lb_word_t;

  function automatic logic [LB_PIX_W-1:0] rgb888(input logic [7:0] r,
                                                 input logic [7:0] g,
                                                 input logic [7:0] b);
    return {r, g, b};
  endfunction

  function automatic lb_word_t lb_pack(input logic [LB_PIX_W-1:0] color_even,
                                       input logic [LB_PIX_W-1:0] color);
    lb_word_t w;
    w.color_even = color_even;
    w.color      = color;
    return w;
  endfunction

endpackage

// File: rtl/lvds_line_buffer_if.sv
// Valid/ready stream carrying dual-pixel words from the pixel source into the line buffer.
interface lvds_line_buffer_if
  import lvds_line_buffer_pkg::*;
#(
    parameter int DATA_W = LB_WORD_W
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/lvds_line_buffer_ram.sv
// Simple dual-port RAM holding both line banks, addressed as {bank, word}.
// One write port, registered read port; no reset on the array so it maps onto block RAM.
module lvds_line_buffer_ram
  import lvds_line_buffer_pkg::*;
#(
    parameter int ADDR_W = LB_AW + 1,
    parameter int DATA_W = LB_WORD_W
) (
    input  logic              i_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_p1
);

    // Power-of-two depth so the {bank, word} address never leaves the array.
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_p1 <= mem[raddr];
    end

endmodule

// File: rtl/lvds_line_buffer.sv
// Ping-pong line buffer in the pixel clock domain: the source fills one bank while the
// transmitter reads the other; banks swap on every change of the transmitter's y.
module lvds_line_buffer
  import lvds_line_buffer_pkg::*;
#(
    parameter int              HACTIVE        = LB_HACTIVE,
    parameter int              VACTIVE        = LB_VACTIVE,
    parameter int              AW             = LB_AW,
    parameter logic [23:0]     UNDERRUN_COLOR = LB_UNDERRUN_COLOR
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic [11:0]         i_x,
    input  logic [11:0]         i_y,
    output logic [23:0]         o_color,
    output logic [23:0]         o_color_even,
    lvds_line_buffer_if.slave   s_if,
    output logic [11:0]         o_wr_line,
    output logic                o_line_swap,
    output logic                o_underrun,
    input  logic                i_clr_underrun
);

    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(HACTIVE);

    logic                bank_sel;
    logic                wr_bank;
    logic                disp_bank;
    logic [1:0][FW-1:0]  fill;
    logic [FW-1:0]       wr_fill;
    logic [FW-1:0]       disp_fill;
    logic                bank_full;
    logic                wr_en;
    logic [11:0]         y_q;
    logic                swap_p1;
    logic                x_in_range;
    logic [AW-1:0]       rd_word;
    logic                hit_p0;
    logic                hit_p1;
    lb_word_t            rd_word_p1;
    logic [2*24-1:0]     rdata_p1;

    function automatic logic [11:0] next_line(input logic [11:0] y);
        if (32'(y) + 32'd1 == 32'(VACTIVE)) begin
            return 12'd0;
        end
        return y + 12'd1;
    endfunction

    assign wr_bank   = bank_sel;
    assign disp_bank = ~bank_sel;
    assign wr_fill   = fill[wr_bank];
    assign disp_fill = fill[disp_bank];
    assign bank_full = (wr_fill >= FILL_FULL);

    // The swap cycle itself takes no word so the fill being cleared is never raced.
    assign s_if.s_ready = !bank_full && !swap_p1;
    assign wr_en        = s_if.s_valid && s_if.s_ready;
    assign o_line_swap  = swap_p1;

    // ---- stage p0 -> p1: swap detection, bank control, fill counters ----
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            y_q        <= '0;
            swap_p1    <= 1'b0;
            bank_sel   <= 1'b0;
            fill       <= '0;
            o_wr_line  <= 12'd1;
            o_underrun <= 1'b0;
        end else begin
            y_q     <= i_y;
            swap_p1 <= (i_y != y_q);

            if (swap_p1) begin
                bank_sel        <= ~bank_sel;
                fill[disp_bank] <= '0;
                o_wr_line       <= next_line(y_q);
            end else if (wr_en) begin
                fill[wr_bank] <= wr_fill + FW'(1);
            end

            if (swap_p1 && !bank_full) begin
                o_underrun <= 1'b1;
            end else if (i_clr_underrun) begin
                o_underrun <= 1'b0;
            end
        end
    end

    // Out-of-range x reads word 0 but is always reported as unwritten.
    assign x_in_range = (32'(i_x) < 32'(HACTIVE));
    assign rd_word    = x_in_range ? i_x[AW-1:0] : '0;
    assign hit_p0     = x_in_range && (32'(i_x) < 32'(disp_fill));

    lvds_line_buffer_ram #(
        .ADDR_W (FW),
        .DATA_W (2 * 24)
    ) u_ram (
        .i_clk    (i_clk),
        .we       (wr_en),
        .waddr    ({wr_bank, wr_fill[AW-1:0]}),
        .wdata    (s_if.s_data),
        .raddr    ({disp_bank, rd_word}),
        .rdata_p1 (rdata_p1)
    );

    // ---- stage p1: read data qualified by the fill sampled with the address ----
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            hit_p1 <= 1'b0;
        end else begin
            hit_p1 <= hit_p0;
        end
    end

    assign rd_word_p1   = lb_word_t'(rdata_p1);
    assign o_color      = hit_p1 ? rd_word_p1.color      : UNDERRUN_COLOR;
    assign o_color_even = hit_p1 ? rd_word_p1.color_even : UNDERRUN_COLOR;

endmodule

// File: tb/tb_lvds_line_buffer.sv
// Directed bench for the LVDS ping-pong line buffer: fill, overflow hold-off, underrun,
// vertical-blank swap, swap/write collision and mid-line reset.
module tb_lvds_line_buffer;

    localparam logic [47:0] UNDER = {24'hFF00FF, 24'hFF00FF};

    logic        i_clk;
    logic        i_resetn;
    logic [11:0] i_x;
    logic [11:0] i_y;
    logic [23:0] o_color;
    logic [23:0] o_color_even;
    logic [11:0] o_wr_line;
    logic        o_line_swap;
    logic        o_underrun;
    logic        i_clr_underrun;

    int n_cmp;
    int n_err;

    lvds_line_buffer_if src_if ();

    lvds_line_buffer dut (
        .i_clk          (i_clk),
        .i_resetn       (i_resetn),
        .i_x            (i_x),
        .i_y            (i_y),
        .o_color        (o_color),
        .o_color_even   (o_color_even),
        .s_if           (src_if),
        .o_wr_line      (o_wr_line),
        .o_line_swap    (o_line_swap),
        .o_underrun     (o_underrun),
        .i_clr_underrun (i_clr_underrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] word_of(input logic [23:0] base, input int k);
        return {base + 24'(k), base + 24'(k + 1)};
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_words(input int n, input logic [23:0] base);
        int  k = 0;
        int  guard = 0;
        logic acc;
        while (k < n && guard < 4 * n + 10) begin
            src_if.s_valid = 1'b1;
            src_if.s_data  = word_of(base, k);
            @(negedge i_clk);
            acc = src_if.s_ready;
            cyc();
            if (acc) k++;
            guard++;
        end
        src_if.s_valid = 1'b0;
        chk("send_count", 48'(k), 48'(n));
    endtask

    task automatic rd(input string tag, input int x, input logic [47:0] exp);
        i_x = 12'(x);
        cyc();
        chk(tag, {o_color_even, o_color}, exp);
    endtask

    task automatic do_swap(input string tag, input int new_y, input int exp_line, input logic exp_und);
        i_y = 12'(new_y);
        @(negedge i_clk);
        chk({tag, "_nopulse_t"}, 48'(o_line_swap), 48'd0);
        cyc();
        @(negedge i_clk);
        chk({tag, "_pulse"}, 48'(o_line_swap), 48'd1);
        chk({tag, "_ready_gate"}, 48'(src_if.s_ready), 48'd0);
        cyc();
        @(negedge i_clk);
        chk({tag, "_pulse_end"}, 48'(o_line_swap), 48'd0);
        chk({tag, "_wr_line"}, 48'(o_wr_line), 48'(exp_line));
        chk({tag, "_underrun"}, 48'(o_underrun), 48'(exp_und));
        cyc();
    endtask

    initial begin
        int swaps;
        n_cmp = 0;
        n_err = 0;
        i_resetn       = 1'b0;
        i_x            = '0;
        i_y            = '0;
        i_clr_underrun = 1'b0;
        src_if.s_valid = 1'b0;
        src_if.s_data  = '0;

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_color", {o_color_even, o_color}, UNDER);
        chk("rst_ready", 48'(src_if.s_ready), 48'd1);
        chk("rst_wr_line", 48'(o_wr_line), 48'd1);
        chk("rst_swap", 48'(o_line_swap), 48'd0);
        chk("rst_underrun", 48'(o_underrun), 48'd0);
        i_resetn = 1'b1;
        cyc();

        // Full line 1, then keep pushing: the bank must hold off the source.
        send_words(960, 24'd0);
        src_if.s_valid = 1'b1;
        src_if.s_data  = word_of(24'd999, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("full_holdoff", 48'(src_if.s_ready), 48'd0);
            cyc();
        end
        src_if.s_valid = 1'b0;

        do_swap("sw01", 1, 2, 1'b0);
        rd("rd_x5", 5, {24'd5, 24'd6});
        rd("rd_x0", 0, {24'd0, 24'd1});
        rd("rd_x959", 959, {24'd959, 24'd960});
        rd("rd_x1000_clamp", 1000, UNDER);
        rd("rd_x4095_clamp", 4095, UNDER);

        // Short line: 500 words then swap.
        send_words(500, 24'h100000);
        @(negedge i_clk);
        chk("short_ready", 48'(src_if.s_ready), 48'd1);
        cyc();
        do_swap("sw12", 2, 3, 1'b1);
        rd("short_x499", 499, word_of(24'h100000, 499));
        rd("short_x500", 500, UNDER);
        rd("short_x959", 959, UNDER);
        i_clr_underrun = 1'b1;
        cyc();
        i_clr_underrun = 1'b0;
        @(negedge i_clk);
        chk("clr_underrun", 48'(o_underrun), 48'd0);
        cyc();

        // Last active line, then vertical-blank entry.
        send_words(960, 24'h300000);
        do_swap("sw_to1199", 1199, 0, 1'b0);
        send_words(960, 24'h500000);
        do_swap("sw_vblank", 0, 1, 1'b0);
        swaps = 0;
        for (int i = 0; i < 2000; i++) begin
            i_x = 12'(i % 1100);
            @(negedge i_clk);
            if (o_line_swap) swaps++;
            cyc();
        end
        chk("vblank_no_swap", 48'(swaps), 48'd0);
        rd("vblank_x0", 0, word_of(24'h500000, 0));
        rd("vblank_x959", 959, word_of(24'h500000, 959));

        // Underrun set wins over a clear held across the swap.
        i_clr_underrun = 1'b1;
        do_swap("sw_setwins", 1, 2, 1'b1);
        i_clr_underrun = 1'b0;
        i_clr_underrun = 1'b1;
        cyc();
        i_clr_underrun = 1'b0;
        @(negedge i_clk);
        chk("clr_after_setwins", 48'(o_underrun), 48'd0);
        cyc();

        // Last word accepted in the cycle y changes; it must land in the outgoing bank.
        send_words(959, 24'h700000);
        i_y = 12'd2;
        src_if.s_valid = 1'b1;
        src_if.s_data  = word_of(24'h700000, 959);
        @(negedge i_clk);
        chk("coll_ready_t", 48'(src_if.s_ready), 48'd1);
        cyc();
        @(negedge i_clk);
        chk("coll_ready_swap", 48'(src_if.s_ready), 48'd0);
        chk("coll_pulse", 48'(o_line_swap), 48'd1);
        cyc();
        src_if.s_valid = 1'b0;
        @(negedge i_clk);
        chk("coll_wr_line", 48'(o_wr_line), 48'd3);
        chk("coll_underrun", 48'(o_underrun), 48'd0);
        chk("coll_new_ready", 48'(src_if.s_ready), 48'd1);
        cyc();
        rd("coll_x959", 959, word_of(24'h700000, 959));
        rd("coll_x0", 0, word_of(24'h700000, 0));

        // Mid-line reset with 300 words in the write bank.
        send_words(300, 24'h800000);
        rd("pre_rst_x0", 0, word_of(24'h700000, 0));
        #2;
        i_resetn = 1'b0;
        i_y      = '0;
        #1;
        chk("midrst_color", {o_color_even, o_color}, UNDER);
        chk("midrst_wr_line", 48'(o_wr_line), 48'd1);
        chk("midrst_ready", 48'(src_if.s_ready), 48'd1);
        chk("midrst_underrun", 48'(o_underrun), 48'd0);
        cyc();
        i_resetn = 1'b1;
        cyc();
        rd("postrst_x0", 0, UNDER);
        rd("postrst_x299", 299, UNDER);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lvds_line_buffer.md
Name: lvds_line_buffer

Overview:
- Ping-pong line buffer that sits directly upstream of the dual-pixel LVDS transmitter, in the pixel clock domain (the divided-by-3.5 clock).
- A pixel source streams each line as 48-bit dual-pixel words through a valid/ready handshake.
- The transmitter's x/y outputs index the buffer, and the block returns color/color_even for that position.
- Banks swap once per active line, so the source always fills line n+1 while line n is displayed.

Parameters:
HACTIVE, 960, dual-pixel words per line (matches transmitter active width)
VACTIVE, 1200, active lines per frame
AW, 10, word address width; 2**AW >= HACTIVE
UNDERRUN_COLOR, 24'hFF00FF, colour driven for words never written to the display bank

Ports:
i_clk  in  1  pixel clock, same clock as the transmitter slot counter
i_resetn  in  1  asynchronous active-low reset
i_x  in  12  transmitter x (0..HACTIVE-1; 0 during blanking)
i_y  in  12  transmitter y (0..VACTIVE-1; 0 during vertical blanking)
o_color  out  24  odd pixel, {R8,G8,B8}
o_color_even  out  24  even pixel, {R8,G8,B8}
s_data  in  48  {color_even, color} word from the source
s_valid  in  1  source word valid
s_ready  out  1  buffer accepts a word this cycle
o_wr_line  out  12  line number the source must currently be sending
o_line_swap  out  1  one-cycle pulse when banks swap (source restarts at word 0)
o_underrun  out  1  sticky: a bank was displayed while incomplete
i_clr_underrun  in  1  synchronous clear of o_underrun

Behaviour:
Reset (async assert, sync-safe deassert):
- bank_sel=0 and both fill counters=0.
- y_q=0; o_wr_line=1.
- s_ready=1; o_line_swap=0; o_underrun=0.
- o_color and o_color_even = UNDERRUN_COLOR.

Write side:
- Word accepted when s_valid & s_ready.
- Accepted word is stored at wr_addr=fill[wr_bank], then fill is incremented.
- s_ready = (fill[wr_bank] < HACTIVE). A full bank holds off the source with no overflow.

Swap detection:
- y_q registers i_y every cycle.
- Swap fires in cycle t+1 when i_y != y_q in cycle t.
- At a swap:
  - bank_sel toggles; the display bank becomes the write bank.
  - The new write bank's fill resets to 0.
  - o_line_swap pulses.
  - o_wr_line = (i_y_new+1 == VACTIVE) ? 0 : i_y_new+1.
- The y transition 1199->0 at vertical-blank entry is a swap. Line 0 is therefore held in the display bank for the whole blanking interval.
- Exactly VACTIVE swaps per frame; no swaps during vertical blanking.

Swap / write collision:
- A word accepted in the swap cycle goes to the old write bank, which is now the display bank, and counts in its fill.
- Writes are gated off (s_ready=0) in the swap cycle itself.

Underrun:
- At a swap, if the outgoing write bank has fill < HACTIVE, o_underrun is set.
- Set wins over i_clr_underrun in the same cycle.

Read side:
- Synchronous RAM read at address i_x of the display bank.
- o_color/o_color_even are registered with 1-cycle latency from i_x.
- If i_x >= fill[disp_bank] (sampled with the address), the outputs are UNDERRUN_COLOR instead of RAM data.
- i_x >= HACTIVE is clamped: treated as an unwritten word.

Timing:
- The transmitter guarantees i_y changes at least 24 cycles (hfront) before the first active x. The 1-cycle swap delay is therefore invisible on screen.

Reset mid-line:
- All state returns to reset values.
- The source must restart at word 0 of o_wr_line.
- The first displayed line after reset shows UNDERRUN_COLOR.

Decomposition:
- Include file lvds_timing.vh holds HACTIVE, VACTIVE, HFRONT, VFRONT and the colour packing macros. The transmitter and this block both use it.
- Sub-module lvds_lb_ram: simple dual-port RAM, 2*HACTIVE x 48, one write port, synchronous read port. Address = {bank, word}. Maps to Gowin BSRAM.

Test Plan:
- Reset, then send 960 words (word k = {24'(k), 24'(k+1)}) and step i_y 0->1 -> o_line_swap pulses once; o_wr_line=2; for i_x=5, one cycle later o_color=6 and o_color_even=5.
- Keep s_valid=1 beyond 960 words -> s_ready drops after word 960 and fill stays 960; no overwrite (i_x=959 returns word 959).
- Send only 500 words, then swap -> o_underrun=1; i_x=499 gives data; i_x=500..959 give 24'hFF00FF; i_clr_underrun clears the flag.
- i_y 1199->0 with a full write bank -> swap, o_wr_line=1; hold i_y=0 for 26 lines -> no further swaps, and line 0 is still read back correctly.
- Word accepted in the same cycle as the swap -> counted in the display bank, s_ready=0 that cycle, new write bank fill=0.
- Assert i_resetn=0 mid-line at fill=300 -> outputs immediately UNDERRUN_COLOR; o_wr_line=1; fill=0; s_ready=1.
